// File: rtl/lock_supervisor.sv
// Supervisor between the user key input and the serial lock core: gates the key bit,
// drives the core reset, counts failures, enforces lockout and times the door window.
module lock_supervisor #(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned CNT_W          = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_x,
  input  logic             alarm_clr,
  input  logic             lock_ready,
  input  logic             lock_unlock,
  input  logic             lock_error,
  output logic             lock_x,
  output logic             lock_reset,
  output logic             door_open,
  output logic             lockout,
  output logic [CNT_W-1:0] fail_count,
  output logic             alarm
);

  localparam int unsigned TMax = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int unsigned TW   = ($clog2(TMax) > 0) ? $clog2(TMax) : 1;

  typedef enum logic [1:0] {StNormal, StOpen, StRelock, StLockout} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] fail_d;
  logic [CNT_W:0]   fail_inc;
  logic             unl_d, err_d;
  logic             unl_ev, err_ev;
  logic             alarm_set;

  // Core readiness is informational only.
  logic unused_ready;
  assign unused_ready = lock_ready;

  assign unl_ev   = lock_unlock & ~unl_d;
  assign err_ev   = lock_error & ~err_d;
  assign fail_inc = {1'b0, fail_count} + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    fail_d    = fail_count;
    alarm_set = 1'b0;
    unique case (state_q)
      StNormal: begin
        if (unl_ev) begin
          fail_d  = '0;
          timer_d = TW'(OPEN_CYCLES - 1);
          state_d = StOpen;
        end else if (err_ev) begin
          if (fail_inc < (CNT_W+1)'(MAX_FAIL)) begin
            fail_d = fail_inc[CNT_W-1:0];
          end else begin
            fail_d    = CNT_W'(MAX_FAIL);
            alarm_set = 1'b1;
            timer_d   = TW'(LOCKOUT_CYCLES - 1);
            state_d   = StLockout;
          end
        end
      end
      StOpen: begin
        if (timer_q == '0) state_d = StRelock;
        else               timer_d = timer_q - 1'b1;
      end
      StRelock: state_d = StNormal;
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StNormal;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StNormal;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StNormal;
      timer_q    <= '0;
      fail_count <= '0;
      unl_d      <= 1'b0;
      err_d      <= 1'b0;
      lock_reset <= 1'b1;
      door_open  <= 1'b0;
      lockout    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_count <= fail_d;
      unl_d      <= lock_unlock;
      err_d      <= lock_error;
      lock_reset <= (state_d == StRelock) || (state_d == StLockout);
      door_open  <= (state_d == StOpen);
      lockout    <= (state_d == StLockout);
      alarm      <= alarm_set | (alarm & ~alarm_clr);
    end
  end

  // Key path is combinational so the core sees key bits without added latency.
  assign lock_x = (state_q == StNormal) & ~reset & key_x;

endmodule
